// File: rtl/solver_dispatcher.sv
// Dispatcher that loads N solver threads in turn, starts them together and collects the first SAT or all-done outcome.
// Optional WAIT watchdog enabled by defining SOLVER_DISPATCHER_TIMEOUT_EN.
module solver_dispatcher #(
  parameter int unsigned NUM_THREADS    = 4,
  parameter int unsigned THREAD_W       = $clog2(NUM_THREADS),
  parameter int unsigned LOAD_ADDR_W    = 12,
  parameter int unsigned LOAD_DATA_W    = 64,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h00FF_FFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_start,
  input  logic                   load_valid,
  input  logic [1:0]             load_sel,
  input  logic [LOAD_ADDR_W-1:0] load_addr,
  input  logic [LOAD_DATA_W-1:0] load_data,
  input  logic                   load_end,
  output logic [NUM_THREADS-1:0] thr_load_valid,
  output logic [1:0]             thr_load_sel,
  output logic [LOAD_ADDR_W-1:0] thr_load_addr,
  output logic [LOAD_DATA_W-1:0] thr_load_data,
  output logic [NUM_THREADS-1:0] thr_start_run,
  output logic [NUM_THREADS-1:0] thr_abort,
  input  logic [NUM_THREADS-1:0] thr_done,
  input  logic [NUM_THREADS-1:0] thr_sat,
  output logic [THREAD_W-1:0]    load_thread,
  output logic                   cpu_busy,
  output logic                   cpu_done,
  output logic                   result_sat,
  output logic [THREAD_W-1:0]    result_thread,
  output logic                   timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_ABORT,
    S_DONE
  } state_t;

  localparam logic [THREAD_W-1:0]    LAST_THREAD = THREAD_W'(NUM_THREADS - 1);
  localparam logic [NUM_THREADS-1:0] ONE_HOT0    = {{(NUM_THREADS-1){1'b0}}, 1'b1};

  state_t                 state, state_next;
  logic [NUM_THREADS-1:0] done_mask;
  logic [NUM_THREADS-1:0] sat_vec;
  logic                   sat_hit;
  logic                   sat_found;
  logic [THREAD_W-1:0]    sat_idx;
  logic                   all_done;
  logic                   tmo_hit;

`ifdef SOLVER_DISPATCHER_TIMEOUT_EN
  logic [31:0] watchdog;
  assign tmo_hit = (watchdog == TIMEOUT_CYCLES - 32'd1);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // Lowest-index thread reporting SAT this cycle.
  always_comb begin
    sat_vec   = thr_done & thr_sat;
    sat_hit   = |sat_vec;
    sat_found = 1'b0;
    sat_idx   = '0;
    for (int unsigned i = 0; i < NUM_THREADS; i++) begin
      if (sat_vec[i] && !sat_found) begin
        sat_idx   = THREAD_W'(i);
        sat_found = 1'b1;
      end
    end
    all_done = &(done_mask | thr_done);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (cpu_start) state_next = S_LOAD;
      S_LOAD:  if (load_end && load_thread == LAST_THREAD) state_next = S_RUN;
      S_RUN:   state_next = S_WAIT;
      S_WAIT: begin
        if (sat_hit)       state_next = S_ABORT;
        else if (all_done) state_next = S_DONE;
        else if (tmo_hit)  state_next = S_ABORT;
      end
      S_ABORT: state_next = S_DONE;
      S_DONE:  if (cpu_start) state_next = S_LOAD;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_busy      = (state == S_LOAD) || (state == S_RUN) ||
                    (state == S_WAIT) || (state == S_ABORT);
    cpu_done      = (state == S_DONE);
    thr_start_run = (state == S_RUN) ? '1 : '0;
    thr_abort     = (state == S_ABORT) ? ~done_mask : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_thread    <= '0;
      thr_load_valid <= '0;
      thr_load_sel   <= '0;
      thr_load_addr  <= '0;
      thr_load_data  <= '0;
      done_mask      <= '0;
      result_sat     <= 1'b0;
      result_thread  <= '0;
      timeout        <= 1'b0;
`ifdef SOLVER_DISPATCHER_TIMEOUT_EN
      watchdog       <= '0;
`endif
    end else begin
      thr_load_valid <= '0;
      unique case (state)
        S_IDLE: if (cpu_start) load_thread <= '0;
        S_LOAD: begin
          // The beat is steered by the pre-increment thread index.
          if (load_valid && load_sel != 2'd3) begin
            thr_load_valid <= ONE_HOT0 << load_thread;
            thr_load_sel   <= load_sel;
            thr_load_addr  <= load_addr;
            thr_load_data  <= load_data;
          end
          if (load_end && load_thread != LAST_THREAD) load_thread <= load_thread + 1'b1;
        end
        S_RUN: begin
          done_mask <= '0;
`ifdef SOLVER_DISPATCHER_TIMEOUT_EN
          watchdog  <= '0;
`endif
        end
        S_WAIT: begin
          done_mask <= done_mask | thr_done;
`ifdef SOLVER_DISPATCHER_TIMEOUT_EN
          watchdog  <= watchdog + 32'd1;
`endif
          if (sat_hit) begin
            result_sat    <= 1'b1;
            result_thread <= sat_idx;
          end else if (!all_done && tmo_hit) begin
            timeout <= 1'b1;
          end
        end
        S_ABORT: ;
        S_DONE: begin
          if (cpu_start) begin
            result_sat    <= 1'b0;
            result_thread <= '0;
            timeout       <= 1'b0;
            load_thread   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_solver_dispatcher.sv
// Directed self-checking bench for solver_dispatcher (4 threads, watchdog limit 100).
module tb_solver_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_start;
  logic        load_valid;
  logic [1:0]  load_sel;
  logic [11:0] load_addr;
  logic [63:0] load_data;
  logic        load_end;
  logic [3:0]  thr_load_valid;
  logic [1:0]  thr_load_sel;
  logic [11:0] thr_load_addr;
  logic [63:0] thr_load_data;
  logic [3:0]  thr_start_run;
  logic [3:0]  thr_abort;
  logic [3:0]  thr_done;
  logic [3:0]  thr_sat;
  logic [1:0]  load_thread;
  logic        cpu_busy;
  logic        cpu_done;
  logic        result_sat;
  logic [1:0]  result_thread;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  solver_dispatcher #(
    .NUM_THREADS   (4),
    .LOAD_ADDR_W   (12),
    .LOAD_DATA_W   (64),
    .TIMEOUT_CYCLES(32'd100)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_start     (cpu_start),
    .load_valid    (load_valid),
    .load_sel      (load_sel),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .load_end      (load_end),
    .thr_load_valid(thr_load_valid),
    .thr_load_sel  (thr_load_sel),
    .thr_load_addr (thr_load_addr),
    .thr_load_data (thr_load_data),
    .thr_start_run (thr_start_run),
    .thr_abort     (thr_abort),
    .thr_done      (thr_done),
    .thr_sat       (thr_sat),
    .load_thread   (load_thread),
    .cpu_busy      (cpu_busy),
    .cpu_done      (cpu_done),
    .result_sat    (result_sat),
    .result_thread (result_thread),
    .timeout       (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},   64'(cpu_busy),       64'h0);
    chk({tag, "_done"},   64'(cpu_done),       64'h0);
    chk({tag, "_strobe"}, 64'(thr_load_valid), 64'h0);
    chk({tag, "_sel"},    64'(thr_load_sel),   64'h0);
    chk({tag, "_addr"},   64'(thr_load_addr),  64'h0);
    chk({tag, "_data"},   thr_load_data,       64'h0);
    chk({tag, "_run"},    64'(thr_start_run),  64'h0);
    chk({tag, "_abort"},  64'(thr_abort),      64'h0);
    chk({tag, "_lthr"},   64'(load_thread),    64'h0);
    chk({tag, "_rsat"},   64'(result_sat),     64'h0);
    chk({tag, "_rthr"},   64'(result_thread),  64'h0);
    chk({tag, "_tmo"},    64'(timeout),        64'h0);
  endtask

  // From LOAD with thread 0: four bare load_end cycles, RUN, then into WAIT.
  task automatic quick_load_to_wait();
    load_end = 1'b1;
    repeat (4) tick();
    load_end = 1'b0;
    chk("ql_run", 64'(thr_start_run), 64'hF);
    tick();
    chk("ql_wait_run_off", 64'(thr_start_run), 64'h0);
  endtask

  initial begin
    rst = 1'b1; cpu_start = 1'b0; load_valid = 1'b0; load_sel = 2'd0;
    load_addr = '0; load_data = '0; load_end = 1'b0; thr_done = '0; thr_sat = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Beat in IDLE is dropped.
    load_valid = 1'b1; load_sel = 2'd1; load_addr = 12'h055; load_data = 64'hAA;
    tick();
    chk("idle_beat_strobe", 64'(thr_load_valid), 64'h0);
    chk("idle_busy", 64'(cpu_busy), 64'h0);
    load_valid = 1'b0;

    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    chk("start_busy", 64'(cpu_busy), 64'h1);
    chk("start_lthr", 64'(load_thread), 64'h0);

    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 3; b++) begin
        load_valid = 1'b1;
        load_sel   = 2'(b);
        load_addr  = 12'(t * 16 + b);
        load_data  = 64'hD000_0000_0000_0000 | 64'(t * 16 + b);
        load_end   = (t == 2 && b == 2);
        tick();
        chk("beat_strobe", 64'(thr_load_valid), 64'(4'b0001 << t));
        chk("beat_addr", 64'(thr_load_addr), 64'(t * 16 + b));
        chk("beat_data", thr_load_data, 64'hD000_0000_0000_0000 | 64'(t * 16 + b));
        chk("beat_sel", 64'(thr_load_sel), 64'(b));
      end
      load_valid = 1'b0;
      load_end   = 1'b0;
      if (t == 1) begin
        load_valid = 1'b1; load_sel = 2'd3; load_addr = 12'hFFF; load_data = '1;
        tick();
        load_valid = 1'b0;
        chk("sel3_strobe", 64'(thr_load_valid), 64'h0);
        chk("sel3_addr_held", 64'(thr_load_addr), 64'h12);
      end
      if (t == 2) begin
        chk("same_cycle_end_lthr", 64'(load_thread), 64'h3);
      end else begin
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        chk("end_strobe", 64'(thr_load_valid), 64'h0);
        chk("end_lthr", 64'(load_thread), (t == 3) ? 64'h3 : 64'(t + 1));
        if (t == 3) chk("run_pulse", 64'(thr_start_run), 64'hF);
      end
    end
    tick();
    chk("run_single", 64'(thr_start_run), 64'h0);
    chk("wait_busy", 64'(cpu_busy), 64'h1);

    // Two threads SAT in the same cycle: lowest wins, the others are aborted.
    thr_done = 4'b0110; thr_sat = 4'b0110;
    tick();
    thr_done = '0; thr_sat = '0;
    chk("sat_rsat", 64'(result_sat), 64'h1);
    chk("sat_rthr", 64'(result_thread), 64'h1);
    chk("sat_abort", 64'(thr_abort), 64'h9);
    chk("sat_not_done", 64'(cpu_done), 64'h0);
    tick();
    chk("sat_done", 64'(cpu_done), 64'h1);
    chk("sat_abort_off", 64'(thr_abort), 64'h0);
    chk("sat_idle_busy", 64'(cpu_busy), 64'h0);
    tick();
    chk("done_hold_rthr", 64'(result_thread), 64'h1);

    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    chk("restart_rsat", 64'(result_sat), 64'h0);
    chk("restart_rthr", 64'(result_thread), 64'h0);
    chk("restart_done", 64'(cpu_done), 64'h0);
    chk("restart_busy", 64'(cpu_busy), 64'h1);
    chk("restart_lthr", 64'(load_thread), 64'h0);

    quick_load_to_wait();

    // All threads finish UNSAT one per cycle.
    for (int i = 0; i < 4; i++) begin
      thr_done = 4'(4'b0001 << i);
      tick();
      chk("unsat_abort", 64'(thr_abort), 64'h0);
      chk("unsat_done", 64'(cpu_done), (i == 3) ? 64'h1 : 64'h0);
    end
    thr_done = '0;
    chk("unsat_rsat", 64'(result_sat), 64'h0);
    chk("unsat_rthr", 64'(result_thread), 64'h0);
    chk("unsat_tmo", 64'(timeout), 64'h0);

    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    quick_load_to_wait();

    repeat (99) tick();
    chk("pre_tmo_busy", 64'(cpu_busy), 64'h1);
    chk("pre_tmo_flag", 64'(timeout), 64'h0);
    tick();
`ifdef SOLVER_DISPATCHER_TIMEOUT_EN
    chk("tmo_flag", 64'(timeout), 64'h1);
    chk("tmo_abort", 64'(thr_abort), 64'hF);
    chk("tmo_rsat", 64'(result_sat), 64'h0);
    tick();
    chk("tmo_done", 64'(cpu_done), 64'h1);
    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    chk("tmo_restart_clear", 64'(timeout), 64'h0);
    quick_load_to_wait();
`else
    chk("no_tmo_busy", 64'(cpu_busy), 64'h1);
    chk("no_tmo_flag", 64'(timeout), 64'h0);
    chk("no_tmo_abort", 64'(thr_abort), 64'h0);
    // A start request while waiting is ignored.
    cpu_start = 1'b1;
    tick();
    cpu_start = 1'b0;
    chk("wait_start_ignored_busy", 64'(cpu_busy), 64'h1);
    chk("wait_start_ignored_lthr", 64'(load_thread), 64'h3);
`endif

    // Reset while waiting: back to IDLE with everything cleared, no abort.
    thr_done = 4'b0001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    thr_done = '0;
    check_all_zero("mid_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
